// File: rtl/twowire_pkg.sv
// Shared Two-Wire Debug definitions: command codes, payload sizing and byte-order helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package twowire_pkg;

  // Command codes, kept 8 bits wide so callers can zero-extend any W_CMD up to 8
  localparam logic [7:0] CMD_DISCONNECT = 8'h0;
  localparam logic [7:0] CMD_R_IDCODE   = 8'h1;
  localparam logic [7:0] CMD_R_CSR      = 8'h2;
  localparam logic [7:0] CMD_W_CSR      = 8'h3;
  localparam logic [7:0] CMD_R_ADDR     = 8'h4;
  localparam logic [7:0] CMD_W_ADDR     = 8'h5;
  localparam logic [7:0] CMD_R_DATA     = 8'h7;
  localparam logic [7:0] CMD_R_BUFF     = 8'h8;
  localparam logic [7:0] CMD_W_DATA     = 8'h9;
  localparam logic [7:0] CMD_R_AINFO    = 8'hB;

  localparam logic [7:0] TWD_VERSION = 8'h01;

  // Widest payload the byteswap helper handles (ASIZE up to 7)
  localparam int TWD_MAX_SREG = 64;

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return (cmd == CMD_W_CSR) || (cmd == CMD_W_ADDR) || (cmd == CMD_W_DATA);
  endfunction

  function automatic logic cmd_is_read(input logic [7:0] cmd);
    return (cmd == CMD_R_IDCODE) || (cmd == CMD_R_CSR) || (cmd == CMD_R_ADDR) ||
           (cmd == CMD_R_DATA) || (cmd == CMD_R_BUFF) || (cmd == CMD_R_AINFO);
  endfunction

  // Payload length in bits; 0 for DISCONNECT and unknown codes
  function automatic int cmd_payload_len(input logic [7:0] cmd, input int asize);
    if ((cmd == CMD_R_ADDR) || (cmd == CMD_W_ADDR)) return 8 * (1 + asize);
    else if (cmd_is_write(cmd) || cmd_is_read(cmd)) return 32;
    else return 0;
  endfunction

  // Reverse the order of the low nbytes bytes; everything above is zeroed
  function automatic logic [TWD_MAX_SREG-1:0] byteswap(input logic [TWD_MAX_SREG-1:0] v,
                                                      input int nbytes);
    logic [TWD_MAX_SREG-1:0] r;
    r = '0;
    for (int i = 0; i < TWD_MAX_SREG / 8; i++) begin
      if (i < nbytes) r[8*i +: 8] = v[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/twowire_shifter.sv
// Payload shift register with bit counter: parallel load, MSB-first shift out, masked shift in.
// Latency: load/shift take effect on the next dck edge; last is combinational from the counter.
// Backpressure: shifts only when shift_en is high, otherwise holds.
module twowire_shifter
  import twowire_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          dck,
  input  logic          drst_n,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic [CW-1:0] load_cnt,
  input  logic          shift_en,
  input  logic          shift_in,
  input  logic [W-1:0]  ins_mask,
  output logic [W-1:0]  sreg,
  output logic          last
);

  logic [CW-1:0] bit_ctr;

  // Load takes priority; each shift moves one bit and counts down towards the final bit
  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      sreg    <= '0;
      bit_ctr <= '0;
    end else if (load) begin
      sreg    <= load_val;
      bit_ctr <= load_cnt;
    end else if (shift_en) begin
      sreg <= (sreg << 1) | (shift_in ? ins_mask : '0);
      if (bit_ctr != '0) bit_ctr <= bit_ctr - CW'(1);
    end
  end

  // Counter at zero means the bit currently on offer is the final one
  assign last = (bit_ctr == '0);

endmodule

// File: rtl/twowire_host_core.sv
// Host-side Two-Wire Debug command engine: request -> PHY command -> payload shift -> response.
// Latency: resp_vld one cycle after the last bit handshake (or after accepting an unknown command).
// Backpressure: one transaction in flight; req_rdy only in IDLE, response held until resp_rdy.
module twowire_host_core
  import twowire_pkg::*;
#(
  parameter  int W_CMD  = 4,
  parameter  int ASIZE  = 0,
  localparam int W_SREG = (8 * (1 + ASIZE) > 32) ? 8 * (1 + ASIZE) : 32
) (
  input  logic              dck,
  input  logic              drst_n,
  input  logic [W_CMD-1:0]  req_cmd,
  input  logic [W_SREG-1:0] req_wdata,
  input  logic              req_vld,
  output logic              req_rdy,
  output logic [W_SREG-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_vld,
  input  logic              resp_rdy,
  output logic [W_CMD-1:0]  phy_cmd,
  output logic              phy_cmd_vld,
  input  logic              phy_cmd_rdy,
  output logic              phy_wdata,
  output logic              phy_wdata_vld,
  input  logic              phy_wdata_rdy,
  input  logic              phy_rdata,
  input  logic              phy_rdata_vld,
  input  logic              phy_parity_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam int CW = $clog2(W_SREG) + 1;

  logic [1:0]        state;
  logic [W_CMD-1:0]  cmd_q;
  logic              err_q;
  logic [7:0]        req_cmd_x, cmd_x;
  logic              req_known, cur_wr, cur_rd;
  int                req_len, cur_len;
  logic [W_SREG-1:0] load_val, ins_mask, sreg, collected;
  logic [CW-1:0]     load_cnt;
  logic              load, shift_en, last;

  assign req_cmd_x = 8'(req_cmd);
  assign cmd_x     = 8'(cmd_q);
  assign req_known = cmd_is_write(req_cmd_x) || cmd_is_read(req_cmd_x) ||
                     (req_cmd_x == CMD_DISCONNECT);
  assign req_len   = cmd_payload_len(req_cmd_x, ASIZE);
  assign cur_len   = cmd_payload_len(cmd_x, ASIZE);
  assign cur_wr    = cmd_is_write(cmd_x);
  assign cur_rd    = cmd_is_read(cmd_x);

  // Wire order is byte 0 first, MSB first per byte: byteswap then left-align and shift MSB-first
  assign load_val = cmd_is_write(req_cmd_x)
                  ? (W_SREG'(byteswap(TWD_MAX_SREG'(req_wdata), req_len / 8)) << (W_SREG - req_len))
                  : '0;
  assign load_cnt = (req_len == 0) ? '0 : CW'(req_len - 1);
  assign load     = (state == S_IDLE) && req_vld && req_known;

  // Read bits enter just below the collected window so a full frame ends up left-aligned
  assign ins_mask = W_SREG'(1) << (W_SREG - cur_len);
  assign shift_en = (state == S_SHIFT) &&
                    (cur_wr ? phy_wdata_rdy : (cur_rd && phy_rdata_vld));

  twowire_shifter #(.W(W_SREG), .CW(CW)) u_shifter (
    .dck      (dck),
    .drst_n   (drst_n),
    .load     (load),
    .load_val (load_val),
    .load_cnt (load_cnt),
    .shift_en (shift_en),
    .shift_in (cur_rd && phy_rdata),
    .ins_mask (ins_mask),
    .sreg     (sreg),
    .last     (last)
  );

  // Transaction sequencing plus sticky parity-error accumulation from CMD through RESP
  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      state <= S_IDLE;
      cmd_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_vld) begin
            cmd_q <= req_cmd;
            err_q <= !req_known;
            state <= req_known ? S_CMD : S_RESP;
          end
        end
        S_CMD: begin
          err_q <= err_q | phy_parity_err;
          if (phy_cmd_rdy) state <= (cmd_x == CMD_DISCONNECT) ? S_RESP : S_SHIFT;
        end
        S_SHIFT: begin
          err_q <= err_q | phy_parity_err;
          if (shift_en && last) state <= S_RESP;
        end
        S_RESP: begin
          err_q <= err_q | phy_parity_err;
          if (resp_rdy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign collected     = sreg >> (W_SREG - cur_len);
  assign req_rdy       = (state == S_IDLE);
  assign resp_vld      = (state == S_RESP);
  assign resp_err      = resp_vld && err_q;
  assign resp_rdata    = (resp_vld && cur_rd)
                       ? W_SREG'(byteswap(TWD_MAX_SREG'(collected), cur_len / 8))
                       : '0;
  assign phy_cmd_vld   = (state == S_CMD);
  assign phy_cmd       = phy_cmd_vld ? cmd_q : '0;
  assign phy_wdata_vld = (state == S_SHIFT) && cur_wr;
  assign phy_wdata     = phy_wdata_vld && sreg[W_SREG-1];

endmodule

// File: doc/twowire_host_core.md
Name: twowire_host_core

Overview:
Host-side command engine for the Two-Wire Debug protocol. It is the initiator counterpart of the DTM core: it accepts one register-level request (command plus write data), presents the command to the host serial PHY, then shifts out the payload or collects it, and returns read data or status. The byte-order and bit-order conversion matches the DTM exactly. The PHY owns line-level framing, parity and turnaround; this block owns payload length, ordering and the request/response handshake.

Parameters:
W_CMD, 4, command width.
ASIZE, 0, DTM address size; ADDR payload is 8*(1+ASIZE) bits; must equal the target DTM's ASIZE.

Ports:
dck  input  1  clock
drst_n  input  1  asynchronous active-low reset
req_cmd  input  W_CMD  command code
req_wdata  input  W_SREG  write payload, right-aligned; W_SREG = max(8*(1+ASIZE),32)
req_vld  input  1  request valid
req_rdy  output  1  request accepted when req_vld && req_rdy
resp_rdata  output  W_SREG  read payload, right-aligned and zero-extended; 0 for writes
resp_err  output  1  parity error during transaction, or unknown command
resp_vld  output  1  response valid
resp_rdy  input  1  response consumed when resp_vld && resp_rdy
phy_cmd  output  W_CMD  command to PHY
phy_cmd_vld  output  1  command valid
phy_cmd_rdy  input  1  PHY has sent command header
phy_wdata  output  1  serial write bit
phy_wdata_vld  output  1  write bit valid
phy_wdata_rdy  input  1  PHY consumed write bit
phy_rdata  input  1  serial read bit
phy_rdata_vld  input  1  read bit valid (one bit per cycle asserted)
phy_parity_err  input  1  single-cycle pulse from PHY on parity mismatch

Behaviour:
- Command classes:
  - Write: 3 W_CSR, 5 W_ADDR, 9 W_DATA.
  - Read: 1 R_IDCODE, 2 R_CSR, 4 R_ADDR, 7 R_DATA, 8 R_BUFF, B R_AINFO.
  - No payload: 0 DISCONNECT.
  - Anything else is unknown.
- Payload length: 8*(1+ASIZE) bits for R_ADDR/W_ADDR; 32 bits for all other read/write commands.
- Wire order: byte 0 (least significant) first; each byte sent MSB first. Equivalent rule: byteswap the payload, left-align it in a W_SREG shift register, shift MSB-first.
- Reset values: state IDLE, req_rdy=1, resp_vld=0, resp_err=0, resp_rdata=0, phy_cmd_vld=0, phy_wdata_vld=0, phy_wdata=0, phy_cmd=0.
- FSM states: IDLE, CMD, SHIFT, RESP.
- IDLE:
  - req_rdy=1.
  - On a known command: latch cmd; load sreg with the byteswapped, left-aligned wdata (zero for reads); set bit_ctr=len-1; clear the error accumulator; go to CMD.
  - On an unknown command: go to RESP with resp_err=1. No PHY activity.
- CMD:
  - phy_cmd_vld=1, phy_cmd=latched cmd.
  - On phy_cmd_rdy: DISCONNECT goes to RESP; otherwise go to SHIFT.
- SHIFT (write):
  - phy_wdata=sreg MSB, phy_wdata_vld=1.
  - On phy_wdata_rdy: shift left, decrement bit_ctr; when bit_ctr==0, go to RESP.
- SHIFT (read):
  - On phy_rdata_vld: shift left with phy_rdata inserted at position W_SREG-len; decrement bit_ctr; when bit_ctr==0, go to RESP.
  - phy_rdata_vld outside SHIFT is ignored.
- RESP:
  - resp_vld=1. resp_rdata = byteswap of the collected value, right-aligned to len bits, upper bits zero.
  - resp_err = sticky OR of phy_parity_err sampled from the CMD entry cycle through the RESP cycle.
  - On resp_rdy: go to IDLE. req_rdy is 0 in every state except IDLE, so there is no overlap.
- Latency: from the PHY's last bit handshake to resp_vld is 1 cycle. An unknown command gives resp_vld the cycle after acceptance.
- A parity pulse coincident with the final bit is still captured.
- Reset mid-transaction returns everything to reset values; the partial frame is abandoned. The PHY is responsible for line recovery.

Decomposition:
- Shared package (twowire_pkg): CMD_* codes, TWD_VERSION, the cmd_is_write/cmd_is_read/cmd_payload_len functions, and the byteswap function. The DTM core is to be refactored onto the same package.
- One natural sub-module: twowire_shifter. It contains the W_SREG shift register with the bit counter, load, shift-in/out and done flag, and is reusable by the DTM core.

Test Plan:
- W_CSR, wdata=0x00011000 -> 32 phy_wdata bits in order: 00000000 00010000 00000001 00000000; then resp_vld, resp_rdata=0, resp_err=0.
- R_IDCODE; PHY supplies bytes EF,BE,AD,DE (each MSB-first), with phy_rdata_vld gaps of 0-3 cycles -> resp_rdata=0xDEADBEEF.
- ASIZE=0, W_ADDR wdata=0xA5 -> exactly 8 bits, 10100101; ASIZE=1, R_ADDR with bytes 34,12 -> resp_rdata=0x00001234.
- DISCONNECT -> one phy_cmd_vld handshake, no data bits, resp_vld next cycle. Unknown cmd 0x6 -> phy_cmd_vld never asserts, resp_err=1, resp_vld the cycle after acceptance.
- phy_parity_err pulse on bit 17 of R_CSR -> resp_err=1. The following W_DATA transaction -> resp_err=0. Hold resp_rdy=0 for 5 cycles -> resp stable and req_rdy=0 throughout.
- Assert drst_n low at bit 10 of W_DATA -> all outputs at reset values. Next R_DATA request completes normally.
